punc_debug_dumper: RTL and testbench

Sequential debug-port reader for the PUnC LC3 processor. On a start pulse it walks a window of PUnC memory through the memory debug port, then optionally all eight registers through the register-file debug port, then the PC. Each captured word is emitted on a valid/ready output stream tagged with its kind and index. It sits outside `PUnC`, on the opposite end of the debug interface: it drives the debug addresses and consumes the debug data.

---
 rtl/punc_debug_pkg.sv | 32 +++
 rtl/punc_debug_dumper.sv | 129 ++++++++++++
 tb/tb_punc_debug_dumper.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/punc_debug_pkg.sv
// Shared types for the PUnC debug-port dumper.
// Kind tags, FSM states and dump phases.
package punc_debug_pkg;

    localparam logic [1:0] DBG_KIND_MEM = 2'd0;
    localparam logic [1:0] DBG_KIND_RF  = 2'd1;
    localparam logic [1:0] DBG_KIND_PC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PH_MEM = 2'd0,
        PH_RF  = 2'd1,
        PH_PC  = 2'd2
    } phase_t;

    // Phase a dump begins in: memory if any words, else registers, else PC.
    function automatic phase_t first_phase(
        input logic [15:0] count,
        input logic        with_rf
    );
        if (count != 16'd0) return PH_MEM;
        if (with_rf)        return PH_RF;
        return PH_PC;
    endfunction

endpackage

// File: rtl/punc_debug_dumper.sv
// Sequential reader of PUnC memory, registers and PC via the debug port.
// Emits one tagged word per valid/ready handshake.
module punc_debug_dumper
    import punc_debug_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic [15:0] word_count,
    input  logic        include_rf,
    output logic        busy,
    output logic        done,
    output logic [15:0] mem_debug_addr,
    input  logic [15:0] mem_debug_data,
    output logic [2:0]  rf_debug_addr,
    input  logic [15:0] rf_debug_data,
    input  logic [15:0] pc_debug_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [1:0]  out_kind,
    output logic [15:0] out_index,
    output logic        out_last
);

    state_t      state;
    state_t      state_next;
    phase_t      phase;
    logic [15:0] ptr;
    logic [15:0] remaining;
    logic [2:0]  reg_idx;
    logic        incl_rf;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic: one FETCH cycle, SEND until handshake, DONE pulse.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_FETCH;
            ST_FETCH: state_next = ST_SEND;
            ST_SEND: begin
                if (out_ready) begin
                    if (phase == PH_PC) state_next = ST_DONE;
                    else                state_next = ST_FETCH;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Counters, phase sequencing and the output holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= PH_MEM;
            ptr       <= 16'd0;
            remaining <= 16'd0;
            reg_idx   <= 3'd0;
            incl_rf   <= 1'b0;
            out_data  <= 16'd0;
            out_kind  <= 2'd0;
            out_index <= 16'd0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ptr       <= base_addr;
                        remaining <= word_count;
                        reg_idx   <= 3'd0;
                        incl_rf   <= include_rf;
                        phase     <= first_phase(word_count, include_rf);
                    end
                end
                ST_FETCH: begin
                    out_last <= (phase == PH_PC);
                    case (phase)
                        PH_MEM: begin
                            out_data  <= mem_debug_data;
                            out_kind  <= DBG_KIND_MEM;
                            out_index <= ptr;
                        end
                        PH_RF: begin
                            out_data  <= rf_debug_data;
                            out_kind  <= DBG_KIND_RF;
                            out_index <= {13'd0, reg_idx};
                        end
                        default: begin
                            out_data  <= pc_debug_data;
                            out_kind  <= DBG_KIND_PC;
                            out_index <= 16'd0;
                        end
                    endcase
                end
                ST_SEND: begin
                    if (out_ready) begin
                        case (phase)
                            PH_MEM: begin
                                ptr       <= ptr + 16'd1;
                                remaining <= remaining - 16'd1;
                                if (remaining == 16'd1)
                                    phase <= incl_rf ? PH_RF : PH_PC;
                            end
                            PH_RF: begin
                                reg_idx <= reg_idx + 3'd1;
                                if (reg_idx == 3'd7) phase <= PH_PC;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_debug_addr = ptr;
    assign rf_debug_addr  = reg_idx;
    assign out_valid      = (state == ST_SEND);
    assign busy           = (state == ST_FETCH) || (state == ST_SEND);
    assign done           = (state == ST_DONE);

endmodule

// File: tb/tb_punc_debug_dumper.sv
// Scoreboard bench for punc_debug_dumper.
// Stimulus pushes expected words; a forked monitor pops on each handshake.
module tb_punc_debug_dumper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = 16'd0;
    logic [15:0] word_count = 16'd0;
    logic        include_rf = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] mem_debug_addr;
    logic [15:0] mem_debug_data;
    logic [2:0]  rf_debug_addr;
    logic [15:0] rf_debug_data;
    logic [15:0] pc_debug_data = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [1:0]  out_kind;
    logic [15:0] out_index;
    logic        out_last;

    logic [15:0] mem [0:65535];
    logic [15:0] rf  [0:7];

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  kind;
        logic [15:0] index;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    assign mem_debug_data = mem[mem_debug_addr];
    assign rf_debug_data  = rf[rf_debug_addr];

    always #5 clk = ~clk;

    punc_debug_dumper dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .word_count(word_count),
        .include_rf(include_rf),
        .busy(busy),
        .done(done),
        .mem_debug_addr(mem_debug_addr),
        .mem_debug_data(mem_debug_data),
        .rf_debug_addr(rf_debug_addr),
        .rf_debug_data(rf_debug_data),
        .pc_debug_data(pc_debug_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_kind(out_kind),
        .out_index(out_index),
        .out_last(out_last)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic [1:0] k,
                        input logic [15:0] i, input logic l);
        exp_t e;
        e.data  = d;
        e.kind  = k;
        e.index = i;
        e.last  = l;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Start a dump and measure cycles from the start cycle to done.
    task automatic run_dump(input string name, input int exp_lat);
        int cyc;
        pulse_start();
        cyc = 1;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(exp_lat));
        @(posedge clk); #1;
        check({name, " done pulse width"}, {63'd0, done}, 64'd0);
        check({name, " idle after"}, {63'd0, busy}, 64'd0);
        check({name, " queue drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, " busy"}, {63'd0, busy}, 64'd0);
        check({name, " done"}, {63'd0, done}, 64'd0);
        check({name, " valid"}, {63'd0, out_valid}, 64'd0);
        check({name, " out word"},
              {29'd0, out_data, out_kind, out_index, out_last}, 64'd0);
        check({name, " mem addr"}, {48'd0, mem_debug_addr}, 64'd0);
        check({name, " rf addr"}, {61'd0, rf_debug_addr}, 64'd0);
    endtask

    initial begin
        logic [34:0] snap;
        logic [15:0] addr_snap;
        int          cyc;
        int          dcnt;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (done) done_cnt++;
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected word",
                                  {29'd0, out_data, out_kind, out_index,
                                   out_last}, 64'd0);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            check("word",
                                  {29'd0, out_data, out_kind, out_index,
                                   out_last}, {29'd0, e});
                        end
                    end
                end
            end
        join_none

        for (int n = 0; n < 8; n++) rf[n] = 16'h0100 + 16'(n);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;

        // Three memory words, no registers, then PC.
        mem[16'h3000] = 16'h1111;
        mem[16'h3001] = 16'h2222;
        mem[16'h3002] = 16'h3333;
        pc_debug_data = 16'h3000;
        base_addr  = 16'h3000;
        word_count = 16'd3;
        include_rf = 1'b0;
        push(16'h1111, 2'd0, 16'h3000, 1'b0);
        push(16'h2222, 2'd0, 16'h3001, 1'b0);
        push(16'h3333, 2'd0, 16'h3002, 1'b0);
        push(16'h3000, 2'd2, 16'h0000, 1'b1);
        run_dump("mem3", 9);

        // Registers only.
        pc_debug_data = 16'h1234;
        base_addr  = 16'h0040;
        word_count = 16'd0;
        include_rf = 1'b1;
        for (int n = 0; n < 8; n++)
            push(16'h0100 + 16'(n), 2'd1, 16'(n), 1'b0);
        push(16'h1234, 2'd2, 16'h0000, 1'b1);
        run_dump("rf only", 19);

        // Address wrap past 0xFFFF.
        mem[16'hFFFE] = 16'hBEEF;
        mem[16'hFFFF] = 16'hCAFE;
        mem[16'h0000] = 16'h0F0F;
        mem[16'h0001] = 16'h1010;
        pc_debug_data = 16'h2000;
        base_addr  = 16'hFFFE;
        word_count = 16'd4;
        include_rf = 1'b0;
        push(16'hBEEF, 2'd0, 16'hFFFE, 1'b0);
        push(16'hCAFE, 2'd0, 16'hFFFF, 1'b0);
        push(16'h0F0F, 2'd0, 16'h0000, 1'b0);
        push(16'h1010, 2'd0, 16'h0001, 1'b0);
        push(16'h2000, 2'd2, 16'h0000, 1'b1);
        run_dump("wrap", 11);

        // Backpressure on the second word plus ignored start pulses.
        dcnt = done_cnt;
        mem[16'h4000] = 16'hA000;
        mem[16'h4001] = 16'hA001;
        mem[16'h4002] = 16'hA002;
        pc_debug_data = 16'h4444;
        base_addr  = 16'h4000;
        word_count = 16'd3;
        include_rf = 1'b1;
        push(16'hA000, 2'd0, 16'h4000, 1'b0);
        push(16'hA001, 2'd0, 16'h4001, 1'b0);
        push(16'hA002, 2'd0, 16'h4002, 1'b0);
        for (int n = 0; n < 8; n++)
            push(16'h0100 + 16'(n), 2'd1, 16'(n), 1'b0);
        push(16'h4444, 2'd2, 16'h0000, 1'b1);
        pulse_start();
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(out_valid && out_index == 16'h4000) && cyc < 20);
        check("bp first word seen", 64'(cyc < 20), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        snap = {out_data, out_kind, out_index, out_last};
        addr_snap = mem_debug_addr;
        check("bp held word", {29'd0, snap},
              {29'd0, 16'hA001, 2'd0, 16'h4001, 1'b0});
        check("bp addr", {48'd0, addr_snap}, 64'h4001);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp valid", {63'd0, out_valid}, 64'd1);
            check("bp stable", {29'd0, out_data, out_kind, out_index,
                                out_last}, {29'd0, snap});
            check("bp addr stable", {48'd0, mem_debug_addr},
                  {48'd0, addr_snap});
        end
        out_ready = 1'b1;
        base_addr  = 16'h0000;
        word_count = 16'd1;
        include_rf = 1'b0;
        pulse_start();
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp done seen", {63'd0, done}, 64'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start in done ignored", {62'd0, busy, done}, 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("stays idle", {62'd0, busy, out_valid}, 64'd0);
        end
        check("bp one done", 64'(done_cnt - dcnt), 64'd1);
        check("bp queue drained", 64'(exp_q.size()), 64'd0);

        // Reset while a word is waiting in SEND.
        dcnt = done_cnt;
        out_ready  = 1'b0;
        base_addr  = 16'h5000;
        word_count = 16'd4;
        include_rf = 1'b1;
        pulse_start();
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 20);
        check("rst send seen", 64'(cyc < 20), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero_outputs("rst in send");
        rst = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("no done after rst", {62'd0, busy, done}, 64'd0);
        end
        check("rst no done count", 64'(done_cnt - dcnt), 64'd0);

        // Full dump after the reset.
        pc_debug_data = 16'h3000;
        base_addr  = 16'h3000;
        word_count = 16'd3;
        include_rf = 1'b0;
        push(16'h1111, 2'd0, 16'h3000, 1'b0);
        push(16'h2222, 2'd0, 16'h3001, 1'b0);
        push(16'h3333, 2'd0, 16'h3002, 1'b0);
        push(16'h3000, 2'd2, 16'h0000, 1'b1);
        run_dump("after rst", 9);
        check("total done pulses", 64'(done_cnt), 64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
